line_tracker_ctrl: RTL and testbench

Converts the three IR line sensors into the 3-bit `mode` command consumed by the motor speed stage. Inputs are synchronised and debounced, then decoded into one of eight drive codes. A lost-line FSM holds, then pivots to search, when no sensor sees the line. Sits directly upstream of the motor block; its `mode` output drives that block's `mode` input unchanged.

---
 rtl/car_defs_pkg.sv | 52 +++++
 rtl/sensor_debounce.sv | 41 ++++
 rtl/line_tracker_ctrl.sv | 100 ++++++++++
 tb/tb_line_tracker_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/car_defs_pkg.sv
// Shared constants for the line-follower car: motor mode codes, the tracker FSM encoding and the
// side encoding. The motor stage imports the same mode codes.
package car_defs;

  localparam logic [2:0] ModeHold      = 3'b000;
  localparam logic [2:0] ModeFwd       = 3'b111;
  localparam logic [2:0] ModeFwdAlt0   = 3'b010;
  localparam logic [2:0] ModeFwdAlt1   = 3'b101;
  localparam logic [2:0] ModeSoftLeft  = 3'b110;
  localparam logic [2:0] ModeSoftRight = 3'b011;
  localparam logic [2:0] ModeHardLeft  = 3'b001;
  localparam logic [2:0] ModeHardRight = 3'b100;

  typedef enum logic [1:0] {
    StTrack  = 2'b00,
    StLost   = 2'b01,
    StSearch = 2'b10,
    StUnused = 2'b11
  } state_e;

  localparam logic SideLeft  = 1'b0;
  localparam logic SideRight = 1'b1;

  // Sensor pattern ([2]=left, [1]=middle, [0]=right) to drive code.
  function automatic logic [2:0] decode_mode(input logic [2:0] pat);
    logic [2:0] m;
    case (pat)
      3'b010, 3'b111: m = ModeFwd;
      3'b110:         m = ModeSoftLeft;
      3'b100:         m = ModeHardLeft;
      3'b011:         m = ModeSoftRight;
      3'b001:         m = ModeHardRight;
      default:        m = ModeHold;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] pivot_mode(input logic side);
    return (side == SideLeft) ? ModeHardLeft : ModeHardRight;
  endfunction

  function automatic logic side_of(input logic [2:0] pat, input logic prev);
    logic s;
    case (pat)
      3'b110, 3'b100: s = SideLeft;
      3'b011, 3'b001: s = SideRight;
      default:        s = prev;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser and debouncer for the three IR line sensors. A pattern reaches deb only
// after it has been seen unchanged at the synchroniser output for DEBOUNCE_CYC+1 cycles.
module sensor_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sensor,
  output logic [2:0] deb
);

  localparam logic [31:0] CntMax = 32'(DEBOUNCE_CYC - 1);

  logic [2:0]  sync1;
  logic [2:0]  sync2;
  logic [2:0]  cand;
  logic [31:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
      cand  <= 3'b000;
      cnt   <= 32'd0;
      deb   <= 3'b000;
    end else begin
      sync1 <= sensor;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= 32'd0;
      end else if (cnt == CntMax) begin
        // cnt saturates here, so deb keeps reloading the same stable value
        deb <= cand;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/line_tracker_ctrl.sv
// Line tracker: debounced sensors are decoded into motor drive codes; when the line is lost the
// car holds for a grace period, then pivots towards the last side seen, reversing periodically.
module line_tracker_ctrl
  import car_defs::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 100_000,
  parameter int unsigned GRACE_CYC    = 5_000_000,
  parameter int unsigned SEARCH_CYC   = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sensor,
  output logic [2:0] mode,
  output logic       lost,
  output logic [1:0] state_dbg
);

  localparam logic [31:0] GraceMax  = 32'(GRACE_CYC - 1);
  localparam logic [31:0] SearchMax = 32'(SEARCH_CYC - 1);

  logic [2:0]  deb;
  state_e      state;
  logic [31:0] tmr;
  logic        last_side;
  logic        dir;

  sensor_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_sensor_debounce (
    .clk    (clk),
    .rst    (rst),
    .sensor (sensor),
    .deb    (deb)
  );

  assign state_dbg = state;

  // A reappearing line is checked before any timer expiry in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StTrack;
      tmr       <= 32'd0;
      last_side <= SideLeft;
      dir       <= SideLeft;
      mode      <= ModeHold;
      lost      <= 1'b0;
    end else begin
      unique case (state)
        StTrack: begin
          if (deb != 3'b000) begin
            mode      <= decode_mode(deb);
            last_side <= side_of(deb, last_side);
          end else begin
            state <= StLost;
            tmr   <= 32'd0;
            mode  <= ModeHold;
            lost  <= 1'b1;
          end
        end
        StLost: begin
          if (deb != 3'b000) begin
            state <= StTrack;
            mode  <= decode_mode(deb);
            lost  <= 1'b0;
          end else if (tmr == GraceMax) begin
            state <= StSearch;
            tmr   <= 32'd0;
            dir   <= last_side;
            mode  <= pivot_mode(last_side);
          end else begin
            tmr  <= tmr + 32'd1;
            mode <= ModeHold;
          end
        end
        StSearch: begin
          if (deb != 3'b000) begin
            state <= StTrack;
            mode  <= decode_mode(deb);
            lost  <= 1'b0;
          end else if (tmr == SearchMax) begin
            dir  <= ~dir;
            tmr  <= 32'd0;
            mode <= pivot_mode(~dir);
          end else begin
            tmr <= tmr + 32'd1;
          end
        end
        StUnused: begin
          state <= StTrack;
          mode  <= ModeHold;
          lost  <= 1'b0;
        end
        default: begin
          state <= StTrack;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_tracker_ctrl.sv
// Randomised bench for line_tracker_ctrl against a behavioural model built from sensor history
// runs and time-since-line-lost arithmetic.
module tb_line_tracker_ctrl;

  localparam int Deb    = 4;
  localparam int Grace  = 8;
  localparam int Search = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sensor;
  logic [2:0] mode;
  logic       lost;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [2:0] hist [0:Deb+2];
  logic [2:0] m_deb;
  logic [2:0] m_mode;
  logic       m_lost;
  logic [1:0] m_state;
  logic       m_in_lost;
  int         m_age;
  logic       m_last;

  always #5 clk = ~clk;

  line_tracker_ctrl #(
    .DEBOUNCE_CYC (Deb),
    .GRACE_CYC    (Grace),
    .SEARCH_CYC   (Search)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sensor    (sensor),
    .mode      (mode),
    .lost      (lost),
    .state_dbg (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
  endtask

  function automatic logic [2:0] ref_decode(input logic [2:0] p);
    case (p)
      3'b010, 3'b111: return 3'b111;
      3'b110:         return 3'b110;
      3'b100:         return 3'b001;
      3'b011:         return 3'b011;
      3'b001:         return 3'b100;
      default:        return 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= Deb + 2; i++) hist[i] = 3'b000;
    m_deb     = 3'b000;
    m_mode    = 3'b000;
    m_lost    = 1'b0;
    m_state   = 2'b00;
    m_in_lost = 1'b0;
    m_age     = 0;
    m_last    = 1'b0;
  endtask

  // One clock edge; s is the sensor value the DUT samples on this edge.
  task automatic model_edge(input logic [2:0] s);
    int   leg;
    logic side;
    logic stable;
    if (m_deb != 3'b000) begin
      m_mode = ref_decode(m_deb);
      if (!m_in_lost) begin
        if (m_deb == 3'b110 || m_deb == 3'b100) m_last = 1'b0;
        else if (m_deb == 3'b011 || m_deb == 3'b001) m_last = 1'b1;
      end
      m_in_lost = 1'b0;
      m_lost    = 1'b0;
      m_state   = 2'b00;
    end else if (!m_in_lost) begin
      m_in_lost = 1'b1;
      m_age     = 0;
      m_mode    = 3'b000;
      m_lost    = 1'b1;
      m_state   = 2'b01;
    end else begin
      m_age++;
      m_lost = 1'b1;
      if (m_age < Grace) begin
        m_mode  = 3'b000;
        m_state = 2'b01;
      end else begin
        leg     = (m_age - Grace) / Search;
        side    = m_last ^ leg[0];
        m_mode  = side ? 3'b100 : 3'b001;
        m_state = 2'b10;
      end
    end
    // Sensor history: a value held for Deb+1 samples, two samples back, becomes deb.
    for (int i = Deb + 2; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s;
    stable = 1'b1;
    for (int i = 3; i <= Deb + 2; i++) if (hist[i] != hist[2]) stable = 1'b0;
    if (stable) m_deb = hist[2];
  endtask

  task automatic tick(input logic [2:0] s);
    sensor = s;
    @(posedge clk);
    model_edge(s);
    #1;
    check("mode", 32'(mode), 32'(m_mode));
    check("lost", 32'(lost), 32'(m_lost));
    check("state_dbg", 32'(state_dbg), 32'(m_state));
  endtask

  task automatic ticks(input logic [2:0] s, input int n);
    for (int i = 0; i < n; i++) tick(s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mode", 32'(mode), 32'h0);
    check("rst_lost", 32'(lost), 32'h0);
    check("rst_state", 32'(state_dbg), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int n;
    logic [2:0] pat;
    rst    = 1'b1;
    sensor = 3'b000;
    model_reset();
    #2;
    check("init_mode", 32'(mode), 32'h0);
    check("init_state", 32'(state_dbg), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Forward after reset: mode becomes 111 on the 8th edge.
    ticks(3'b010, 7);
    check("fwd_pre", 32'(mode), 32'h0);
    tick(3'b010);
    check("fwd_lat", 32'(mode), 32'h7);
    ticks(3'b010, 4);

    ticks(3'b110, 10);
    ticks(3'b100, 10);
    check("hard_left", 32'(mode), 32'h1);

    // Short glitch must not pass the debouncer.
    ticks(3'b111, 10);
    ticks(3'b001, 3);
    ticks(3'b111, 10);
    check("glitch", 32'(mode), 32'h7);

    // Lost line after a right-side reading: hold, then pivot right, left, right.
    ticks(3'b011, 10);
    ticks(3'b000, 50);

    // Line reappears exactly at a leg expiry.
    ticks(3'b011, 12);
    n = 0;
    while (!(m_in_lost && m_age == Grace + Search - 8) && n < 100) begin
      tick(3'b000);
      n++;
    end
    check("prio_reached", 32'(n < 100), 32'h1);
    ticks(3'b010, 7);
    check("prio_pre", 32'(mode), 32'h4);
    tick(3'b010);
    check("prio_mode", 32'(mode), 32'h7);
    check("prio_state", 32'(state_dbg), 32'h0);

    // Reset mid-search; afterwards the search starts on the left side.
    ticks(3'b011, 12);
    ticks(3'b000, 30);
    do_reset();
    ticks(3'b000, 9);
    check("post_rst_left", 32'(mode), 32'h1);
    ticks(3'b000, 10);

    // Randomised sensor patterns and hold lengths, with occasional resets.
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      if ($urandom_range(0, 3) == 0) begin
        pat = 3'b000;
        n   = $urandom_range(1, 60);
      end else begin
        pat = 3'($urandom_range(0, 7));
        n   = $urandom_range(1, 12);
      end
      ticks(pat, n);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
